// File: rtl/font_dma_sequencer_pkg.sv
// Shared types and helpers for the font DMA sequencer: FSM state encoding
// and glyph-address sizing functions.
package font_dma_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TXT   = 2'd1,
    ST_GLYPH = 2'd2,
    ST_HOLD  = 2'd3
  } seq_state_e;

  localparam int DEF_NSPR       = 8;
  localparam int DEF_HEIGHT     = 8;
  localparam int DEF_CHARW      = 7;
  localparam int DEF_ADDRW      = 9;
  localparam int DEF_TXT_ADDRW  = 11;
  localparam int DEF_FONT_ADDRW = 10;

  // Glyphs are packed back to back in the font ROM, one line per address.
  function automatic int glyph_stride(input int height);
    return height;
  endfunction

  // Width of char_code * stride without overflow.
  function automatic int glyph_prod_width(input int charw, input int height);
    return charw + $clog2(height);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/font_dma_sequencer_if.sv
// Bundle of the frame/line timing, text-buffer, font-ROM and sprite-grant
// signals between the sequencer (master) and the sprite bank / memories (slave).
interface font_dma_sequencer_if #(
  parameter int NSPR       = 8,
  parameter int CHARW      = 7,
  parameter int ADDRW      = 9,
  parameter int TXT_ADDRW  = 11,
  parameter int FONT_ADDRW = 10
);

  logic                    frame;
  logic                    line;
  logic [TXT_ADDRW-1:0]    row_base;
  logic [NSPR*ADDRW-1:0]   spr_pos;
  logic                    spr_start;
  logic [NSPR-1:0]         dma_avail;
  logic [TXT_ADDRW-1:0]    text_addr;
  logic [CHARW-1:0]        text_data;
  logic [FONT_ADDRW-1:0]   font_addr;
  logic                    busy;
  logic                    overrun;

  modport master (
    input  frame, line, row_base, spr_pos, text_data,
    output spr_start, dma_avail, text_addr, font_addr, busy, overrun
  );

  modport slave (
    output frame, line, row_base, spr_pos, text_data,
    input  spr_start, dma_avail, text_addr, font_addr, busy, overrun
  );

endinterface

// File: rtl/font_dma_sequencer.sv
// Per-scan-line glyph fetch sequencer: walks NSPR sprites, looks up each char code,
// drives the font ROM address and grants each sprite a one-cycle DMA slot.
module font_dma_sequencer
  import font_dma_sequencer_pkg::*;
#(
  parameter int NSPR       = DEF_NSPR,
  parameter int HEIGHT     = DEF_HEIGHT,
  parameter int CHARW      = DEF_CHARW,
  parameter int ADDRW      = DEF_ADDRW,
  parameter int TXT_ADDRW  = DEF_TXT_ADDRW,
  parameter int FONT_ADDRW = DEF_FONT_ADDRW
) (
  input  logic                  clk,
  input  logic                  rst_n,
  font_dma_sequencer_if.master  bus
);

  localparam int IDXW         = (NSPR > 1) ? $clog2(NSPR) : 1;
  localparam int GLYPH_STRIDE = glyph_stride(HEIGHT);
  localparam int PRODW        = glyph_prod_width(CHARW, HEIGHT);
  localparam int SUMW         = max_int(PRODW, ADDRW) + 1;
  localparam int WIDEW        = max_int(SUMW, FONT_ADDRW);

  seq_state_e              state_q, state_d;
  logic [IDXW-1:0]         idx_q, idx_d;
  logic                    spr_start_q, spr_start_d;
  logic [NSPR-1:0]         dma_avail_q, dma_avail_d;
  logic [TXT_ADDRW-1:0]    text_addr_q, text_addr_d;
  logic [FONT_ADDRW-1:0]   font_addr_q, font_addr_d;
  logic                    busy_q, busy_d;
  logic                    overrun_q, overrun_d;
  logic                    pending_q, pending_d;

  logic [ADDRW-1:0]        pos_arr [NSPR];
  logic [ADDRW-1:0]        pos_sel;
  logic [WIDEW-1:0]        glyph_base;
  logic [WIDEW-1:0]        glyph_sum;
  logic                    grant_ok;
  logic [NSPR-1:0]         grant_vec;
  logic [TXT_ADDRW-1:0]    next_text_addr;
  logic                    last_slot;

  generate
    for (genvar gi = 0; gi < NSPR; gi++) begin : g_pos
      assign pos_arr[gi] = bus.spr_pos[gi*ADDRW +: ADDRW];
    end
  endgenerate

  assign pos_sel        = pos_arr[idx_q];
  // Constant stride: synthesis folds this into shifts/adds.
  assign glyph_base     = WIDEW'(bus.text_data) * WIDEW'(GLYPH_STRIDE);
  assign glyph_sum      = glyph_base + WIDEW'(pos_sel);
  assign grant_ok       = (32'(pos_sel) < 32'(HEIGHT));
  assign grant_vec      = NSPR'(1) << idx_q;
  assign last_slot      = (idx_q == IDXW'(NSPR - 1));
  assign next_text_addr = bus.row_base + TXT_ADDRW'(idx_q) + TXT_ADDRW'(1);

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spr_start_d = 1'b0;
    dma_avail_d = '0;
    text_addr_d = text_addr_q;
    font_addr_d = font_addr_q;
    overrun_d   = overrun_q;
    pending_d   = pending_q;

    if (bus.frame) begin
      state_d     = ST_IDLE;
      idx_d       = '0;
      spr_start_d = 1'b1;
      overrun_d   = 1'b0;
      pending_d   = bus.line;
      text_addr_d = bus.row_base;
    end else begin
      // The text RAM has one cycle of latency, so the address for slot i is
      // presented one cycle ahead of TXT and its char code is valid during TXT.
      unique case (state_q)
        ST_IDLE: begin
          idx_d       = '0;
          text_addr_d = bus.row_base;
          if (bus.line || pending_q) begin
            state_d   = ST_TXT;
            pending_d = 1'b0;
          end
        end
        ST_TXT: begin
          font_addr_d = glyph_sum[FONT_ADDRW-1:0];
          dma_avail_d = grant_ok ? grant_vec : '0;
          state_d     = ST_GLYPH;
        end
        ST_GLYPH: begin
          text_addr_d = last_slot ? bus.row_base : next_text_addr;
          state_d     = ST_HOLD;
        end
        ST_HOLD: begin
          if (last_slot) begin
            state_d = ST_IDLE;
            idx_d   = '0;
          end else begin
            state_d = ST_TXT;
            idx_d   = idx_q + IDXW'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (bus.line && (state_q != ST_IDLE)) begin
        overrun_d = 1'b1;
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      spr_start_q <= 1'b0;
      dma_avail_q <= '0;
      text_addr_q <= '0;
      font_addr_q <= '0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spr_start_q <= spr_start_d;
      dma_avail_q <= dma_avail_d;
      text_addr_q <= text_addr_d;
      font_addr_q <= font_addr_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
    end
  end

  assign bus.spr_start = spr_start_q;
  assign bus.dma_avail = dma_avail_q;
  assign bus.text_addr = text_addr_q;
  assign bus.font_addr = font_addr_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

endmodule

// File: tb/tb_font_dma_sequencer.sv
// Scoreboard bench for font_dma_sequencer: directed line/frame scenarios with
// text RAM, font ROM and four sprite line-capture models.
module tb_font_dma_sequencer;

  localparam int NSPR       = 4;
  localparam int HEIGHT     = 8;
  localparam int CHARW      = 7;
  localparam int ADDRW      = 9;
  localparam int TXT_ADDRW  = 11;
  localparam int FONT_ADDRW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  font_dma_sequencer_if #(
    .NSPR(NSPR), .CHARW(CHARW), .ADDRW(ADDRW),
    .TXT_ADDRW(TXT_ADDRW), .FONT_ADDRW(FONT_ADDRW)
  ) bus ();

  font_dma_sequencer #(
    .NSPR(NSPR), .HEIGHT(HEIGHT), .CHARW(CHARW), .ADDRW(ADDRW),
    .TXT_ADDRW(TXT_ADDRW), .FONT_ADDRW(FONT_ADDRW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [CHARW-1:0] text_mem [2**TXT_ADDRW];
  logic [7:0]       font_data;
  logic [NSPR-1:0]  dma_dly;
  logic [7:0]       spr_line [NSPR];
  int               cyc = 0;

  function automatic logic [7:0] rom_val(input int a);
    logic [7:0] lo;
    lo = 8'(a);
    return lo ^ 8'hA5;
  endfunction

  // Sync text RAM, sync font ROM, and sprites latching the ROM word the cycle after their grant.
  always @(posedge clk) begin
    cyc           <= cyc + 1;
    bus.text_data <= text_mem[bus.text_addr];
    font_data     <= rom_val(int'(bus.font_addr));
    dma_dly       <= bus.dma_avail;
    for (int i = 0; i < NSPR; i++) begin
      if (dma_dly[i]) spr_line[i] <= font_data;
    end
  end

  typedef enum int {K_DMA, K_TXTA, K_SPR, K_BUSY, K_OVR} kind_e;
  typedef struct {
    int    cyc;
    kind_e kind;
    int    val;
    int    val2;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic push(input int c, input kind_e k, input int v, input int v2);
    exp_t e;
    e.cyc = c; e.kind = k; e.val = v; e.val2 = v2;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0d want=%0d", name, cyc, got, want);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    bit   dma_seen;
    dma_seen = 1'b0;
    if (rst_n) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
        if (sb[i].cyc <= cyc) begin
          e = sb[i];
          sb.delete(i);
          if (e.cyc < cyc) begin
            chk("missed_expectation", e.cyc, cyc);
          end else begin
            case (e.kind)
              K_DMA: begin
                dma_seen = 1'b1;
                chk("dma_avail", int'(bus.dma_avail), e.val);
                chk("font_addr", int'(bus.font_addr), e.val2);
              end
              K_TXTA: chk("text_addr", int'(bus.text_addr), e.val);
              K_SPR:  chk("spr_start", int'(bus.spr_start), e.val);
              K_BUSY: chk("busy", int'(bus.busy), e.val);
              K_OVR:  chk("overrun", int'(bus.overrun), e.val);
              default: chk("bad_kind", int'(e.kind), 0);
            endcase
          end
        end
      end
      if (!dma_seen && bus.dma_avail != '0) begin
        chk("unexpected_grant", int'(bus.dma_avail), 0);
      end
    end
  end

  // Queue the expected per-slot text address and grant for a sequence whose
  // first text address is presented in cycle t0 (grant for slot i at t0+2+3i).
  task automatic expect_seq(input int t0, input int rb, input int fa[NSPR],
                            input logic [NSPR-1:0] en, input int n);
    push(t0 + 1, K_BUSY, 1, 0);
    for (int i = 0; i < n; i++) begin
      push(t0 + 3*i, K_TXTA, (rb + i) % (2**TXT_ADDRW), 0);
      push(t0 + 2 + 3*i, K_DMA, en[i] ? (1 << i) : 0, fa[i]);
    end
    if (n == NSPR) push(t0 + 3*NSPR + 1, K_BUSY, 0, 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_line();
    bus.line = 1'b1;
    tick(1);
    bus.line = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.frame = 1'b1;
    tick(1);
    bus.frame = 1'b0;
  endtask

  task automatic set_pos(input int p0, input int p1, input int p2, input int p3);
    bus.spr_pos = {ADDRW'(p3), ADDRW'(p2), ADDRW'(p1), ADDRW'(p0)};
  endtask

  task automatic chk_sprites(input string name, input int fa[NSPR]);
    for (int i = 0; i < NSPR; i++) chk(name, int'(spr_line[i]), int'(rom_val(fa[i])));
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_dma"}, int'(bus.dma_avail), 0);
    chk({name, "_busy"}, int'(bus.busy), 0);
    chk({name, "_ovr"}, int'(bus.overrun), 0);
    chk({name, "_start"}, int'(bus.spr_start), 0);
    chk({name, "_taddr"}, int'(bus.text_addr), 0);
    chk({name, "_faddr"}, int'(bus.font_addr), 0);
  endtask

  initial begin
    int fa[NSPR];
    int t0;
    bus.frame = 1'b0;
    bus.line  = 1'b0;
    bus.row_base = '0;
    bus.spr_pos  = '0;
    for (int a = 0; a < 2**TXT_ADDRW; a++) text_mem[a] = '0;
    text_mem[100] = 7'd65; text_mem[101] = 7'd66; text_mem[102] = 7'd67; text_mem[103] = 7'd68;
    for (int a = 200; a < 204; a++) text_mem[a] = 7'd1;
    text_mem[300] = 7'd10; text_mem[301] = 7'd20; text_mem[302] = 7'd30; text_mem[303] = 7'd40;
    text_mem[400] = 7'd5;  text_mem[401] = 7'd6;  text_mem[402] = 7'd7;  text_mem[403] = 7'd8;

    tick(2);
    chk_all_zero("reset");
    rst_n = 1'b1;

    // Basic sequence: codes 65..68, pos 0
    bus.row_base = 11'd100; set_pos(0, 0, 0, 0);
    tick(2);
    t0 = cyc; fa = '{520, 528, 536, 544};
    expect_seq(t0, 100, fa, 4'b1111, NSPR);
    pulse_line(); tick(15);
    chk_sprites("sprite_line_basic", fa);

    // pos=3 on all, code 1
    bus.row_base = 11'd200; set_pos(3, 3, 3, 3);
    tick(2);
    t0 = cyc; fa = '{11, 11, 11, 11};
    expect_seq(t0, 200, fa, 4'b1111, NSPR);
    pulse_line(); tick(15);

    // pos=8 on sprite 2 suppresses its grant only
    set_pos(3, 3, 8, 3);
    tick(2);
    t0 = cyc; fa = '{11, 11, 16, 11};
    expect_seq(t0, 200, fa, 4'b1011, NSPR);
    pulse_line(); tick(15);

    // Re-pulsed line mid-sequence: ignored, overrun sticky until frame
    bus.row_base = 11'd300; set_pos(0, 0, 0, 0);
    tick(2);
    t0 = cyc; fa = '{80, 160, 240, 320};
    expect_seq(t0, 300, fa, 4'b1111, NSPR);
    push(t0 + 5, K_OVR, 0, 0);
    push(t0 + 6, K_OVR, 1, 0);
    push(t0 + 14, K_OVR, 1, 0);
    pulse_line(); tick(4);
    pulse_line(); tick(12);
    t0 = cyc;
    push(t0 + 1, K_SPR, 1, 0);
    push(t0 + 1, K_OVR, 0, 0);
    push(t0 + 2, K_SPR, 0, 0);
    pulse_frame(); tick(3);

    // frame and line together: line held pending until after spr_start
    bus.row_base = 11'd400; set_pos(0, 1, 2, 3);
    tick(2);
    t0 = cyc; fa = '{40, 49, 58, 67};
    push(t0 + 1, K_SPR, 1, 0);
    push(t0 + 2, K_SPR, 0, 0);
    expect_seq(t0 + 1, 400, fa, 4'b1111, NSPR);
    bus.frame = 1'b1; bus.line = 1'b1;
    tick(1);
    bus.frame = 1'b0; bus.line = 1'b0;
    tick(16);
    chk_sprites("sprite_line_frame", fa);

    // line during the spr_start cycle: same timing
    bus.row_base = 11'd100; set_pos(0, 0, 0, 0);
    tick(2);
    t0 = cyc; fa = '{520, 528, 536, 544};
    push(t0 + 1, K_SPR, 1, 0);
    expect_seq(t0 + 1, 100, fa, 4'b1111, NSPR);
    pulse_frame();
    pulse_line(); tick(16);

    // frame in cycle 6 aborts the sequence after two grants
    bus.row_base = 11'd300;
    tick(2);
    t0 = cyc; fa = '{80, 160, 240, 320};
    expect_seq(t0, 300, fa, 4'b1111, 2);
    push(t0 + 7, K_SPR, 1, 0);
    push(t0 + 7, K_BUSY, 0, 0);
    push(t0 + 8, K_SPR, 0, 0);
    pulse_line(); tick(5);
    pulse_frame(); tick(14);

    // Async reset in the middle of GLYPH
    bus.row_base = 11'd100;
    tick(2);
    pulse_line(); tick(1);
    chk("pre_reset_grant", int'(bus.dma_avail), 1);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("async_reset");
    tick(2);
    rst_n = 1'b1;
    tick(2);
    t0 = cyc; fa = '{520, 528, 536, 544};
    expect_seq(t0, 100, fa, 4'b1111, NSPR);
    pulse_line(); tick(16);
    chk_sprites("sprite_line_after_reset", fa);

    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
